fu_cdb_tx: RTL and testbench
============================

# fu_cdb_tx

Per-functional-unit completion transmitter: sits between one FU's result pipeline and that FU's CDB slot and drives the slot's `done/T_idx/ROB_idx/dest_idx/result` inputs. Finished results are buffered in a small circular queue and presented oldest-first. A result transfers only when the CDB reports its slot free (`CDB_valid`). Buffered results made wrong-path by a rollback are squashed, and FU issue is throttled through `fu_stall` when the queue fills.

## Interface
- `DEPTH`, 4, queue entries (power of two, ≥2)
- `ROB_W`, 5, ROB index width ($clog2(`NUM_ROB))
- `PR_W`, 6, physical-register tag width ($clog2(`NUM_PR))

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low; the only clock and reset are these two ports
- `en` in 1: global advance enable
- `fu_valid` in 1: FU result valid this cycle
- `fu_T_idx` in PR_W / `fu_ROB_idx` in ROB_W / `fu_dest_idx` in 5 / `fu_result` in 64: FU result fields
- `fu_stall` out 1: queue full; FU must not assert `fu_valid`
- `CDB_valid` in 1: this FU's CDB slot is free (1 = free)
- `rollback_en` in 1: squash request
- `ROB_rollback_idx` in ROB_W: ROB index of the mispredicted instruction
- `diff_ROB` in ROB_W: current ROB tail minus `ROB_rollback_idx`
- `done` out 1: head entry presented to the CDB
- `T_idx` out PR_W / `ROB_idx` out ROB_W / `dest_idx` out 5 / `result` out 64: head entry fields
- `count` out $clog2(DEPTH)+1: occupied slots, including squashed slots not yet drained

## Operation
- **Storage:** `DEPTH` slots, each holding {live, T_idx, ROB_idx, dest_idx, result}, plus `head`, `tail` and `count` registers. Pointers wrap modulo `DEPTH`.
- **Squash test** for an index x: d = (x − `ROB_rollback_idx`) mod 2^ROB_W. The entry is younger, and is squashed, when 1 ≤ d ≤ `diff_ROB`. d = 0 means the rollback instruction itself; it is kept.
- **Rollback** (`rollback_en` & `en`): clear `live` on every occupied slot that passes the squash test. `count`, `head` and `tail` are unchanged.
- **Push** (`fu_valid` & `en` & !`fu_stall`):
  - Write the result at `tail`, then advance `tail`.
  - If `rollback_en` is high in the same cycle and the incoming ROB_idx passes the squash test, do not write it; `tail` and `count` are unchanged.
- **Presentation:**
  - `done` = `en` & (`count` ≠ 0) & head.live & !(`rollback_en` & head passes the squash test).
  - Field outputs always show the head slot; they are don't-care when `done` = 0.
- **Transfer:** `done` & `CDB_valid` → pop the head (advance `head`, decrement `count`).
- **Drain:** `en` & `count` ≠ 0 & !head.live → pop without presenting; one squashed slot is drained per cycle.
- **Stall:** `fu_stall` = (`count` == `DEPTH`) | !`en`. A pop in the same cycle does not lower `fu_stall`.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance.
- **`en` = 0:** all state holds; `done` = 0.
- **Protocol error:** `fu_valid` while `fu_stall` is high. The push is dropped; the bench asserts that this never occurs.

## Timing
- **Reset** (asynchronous on `reset` low): `head` = `tail` = `count` = 0, all `live` = 0. Consequently `done` = 0 and `fu_stall` = 0, and `T_idx`, `ROB_idx`, `dest_idx`, `result` read 0, because slot data also resets to 0. Reset asserted mid-operation discards all entries immediately.
- **Latency:** a push at edge N is presented with `done` = 1 in cycle N+1 when the queue was empty. No combinational bypass from `fu_*` to outputs.
- **Throughput:** one transfer per cycle when `CDB_valid` stays 1. The CDB latches the entry at the same edge that pops it.
- **Combinational paths:** `rollback_en`, `ROB_rollback_idx` and `diff_ROB` reach `done` combinationally. `CDB_valid` affects only next-state logic, never outputs.
- **Squashed slots** cost one drain cycle each before younger live entries are presented.

## Test plan
- **Reset and single result:** reset low, then high; push ROB_idx 3, T_idx 9, result 0xDEAD with `CDB_valid` = 1 → `done` = 1 the next cycle with those fields; `count` returns to 0 one cycle later.
- **Backpressure and full:** hold `CDB_valid` = 0 and push 4 entries → `fu_stall` = 1 and `count` = 4. Raise `CDB_valid` → entries leave in push order, one per cycle, and `fu_stall` drops the cycle after the first pop.
- **Rollback with wrap:** queue ROB_idx {30, 31, 0, 2}; `rollback_en`, `ROB_rollback_idx` = 31, `diff_ROB` = 2 → 31 and 2 are kept, 0 is squashed. Output order is 30, 31, one drain cycle, then 2.
- **Rollback on head:** head ROB_idx 5, `rollback_en`, `ROB_rollback_idx` = 4, `diff_ROB` = 3 → `done` = 0 in that same cycle, and the slot drains the next cycle.
- **Push during rollback:** `fu_valid` with ROB_idx 7 while `ROB_rollback_idx` = 6, `diff_ROB` = 4 → not enqueued, `count` unchanged. The same test with ROB_idx 6 → enqueued.
- **Enable gating and async reset:** `en` = 0 with 2 entries queued → `done` = 0, `fu_stall` = 1, state frozen. Asserting `reset` between clock edges → outputs clear before the next edge.

Source files
------------

// File: rtl/fu_cdb_tx.sv
// Per-FU completion transmitter: buffers finished results in a circular queue and
// presents them oldest-first to this FU's CDB slot, with rollback squash and drain.
module fu_cdb_tx #(
  parameter int DEPTH = 4,
  parameter int ROB_W = 5,
  parameter int PR_W  = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     fu_valid,
  input  logic [PR_W-1:0]          fu_T_idx,
  input  logic [ROB_W-1:0]         fu_ROB_idx,
  input  logic [4:0]               fu_dest_idx,
  input  logic [63:0]              fu_result,
  output logic                     fu_stall,
  input  logic                     CDB_valid,
  input  logic                     rollback_en,
  input  logic [ROB_W-1:0]         ROB_rollback_idx,
  input  logic [ROB_W-1:0]         diff_ROB,
  output logic                     done,
  output logic [PR_W-1:0]          T_idx,
  output logic [ROB_W-1:0]         ROB_idx,
  output logic [4:0]               dest_idx,
  output logic [63:0]              result,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] r_live;
  logic [PR_W-1:0]  r_t_idx    [DEPTH];
  logic [ROB_W-1:0] r_rob_idx  [DEPTH];
  logic [4:0]       r_dest_idx [DEPTH];
  logic [63:0]      r_result   [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_head_sq;
  logic             w_in_sq;
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_slot_sq;

  // Younger-than-rollback test; distance 0 is the mispredicted instruction itself.
  function automatic logic younger(input logic [ROB_W-1:0] x,
                                   input logic [ROB_W-1:0] rb_idx,
                                   input logic [ROB_W-1:0] diff);
    logic [ROB_W-1:0] d;
    d = x - rb_idx;
    return (d != '0) && (d <= diff);
  endfunction

  assign w_head_sq = rollback_en && younger(r_rob_idx[r_head], ROB_rollback_idx, diff_ROB);
  assign w_in_sq   = rollback_en && younger(fu_ROB_idx, ROB_rollback_idx, diff_ROB);

  assign fu_stall  = (r_count == CNT_W'(DEPTH)) || !en;
  assign done      = en && (r_count != '0) && r_live[r_head] && !w_head_sq;
  assign w_push    = fu_valid && en && !fu_stall && !w_in_sq;
  assign w_pop     = (done && CDB_valid) || (en && (r_count != '0) && !r_live[r_head]);

  always_comb begin
    w_slot_sq = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_slot_sq[i] = rollback_en && en
                     && ({1'b0, PTR_W'(PTR_W'(i) - r_head)} < r_count)
                     && younger(r_rob_idx[i], ROB_rollback_idx, diff_ROB);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_live  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_t_idx[i]    <= '0;
        r_rob_idx[i]  <= '0;
        r_dest_idx[i] <= '0;
        r_result[i]   <= '0;
      end
    end else begin
      r_live <= r_live & ~w_slot_sq;
      // The tail slot is never occupied when a push is allowed, so the set cannot clash with a squash.
      if (w_push) begin
        r_live[r_tail]     <= 1'b1;
        r_t_idx[r_tail]    <= fu_T_idx;
        r_rob_idx[r_tail]  <= fu_ROB_idx;
        r_dest_idx[r_tail] <= fu_dest_idx;
        r_result[r_tail]   <= fu_result;
        r_tail             <= r_tail + PTR_W'(1);
      end
      if (w_pop) r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign T_idx    = r_t_idx[r_head];
  assign ROB_idx  = r_rob_idx[r_head];
  assign dest_idx = r_dest_idx[r_head];
  assign result   = r_result[r_head];
  assign count    = r_count;

endmodule

// File: tb/tb_fu_cdb_tx.sv
// Bench for fu_cdb_tx: directed scenarios plus random traffic against a queue-based model.
module tb_fu_cdb_tx;
  localparam int DEPTH = 4;
  localparam int ROB_W = 5;
  localparam int PR_W  = 6;
  localparam int ROBN  = 1 << ROB_W;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              en = 1'b0;
  logic              fu_valid = 1'b0;
  logic [PR_W-1:0]   fu_T_idx = '0;
  logic [ROB_W-1:0]  fu_ROB_idx = '0;
  logic [4:0]        fu_dest_idx = '0;
  logic [63:0]       fu_result = '0;
  logic              CDB_valid = 1'b0;
  logic              rollback_en = 1'b0;
  logic [ROB_W-1:0]  ROB_rollback_idx = '0;
  logic [ROB_W-1:0]  diff_ROB = '0;
  logic              fu_stall, done;
  logic [PR_W-1:0]   T_idx;
  logic [ROB_W-1:0]  ROB_idx;
  logic [4:0]        dest_idx;
  logic [63:0]       result;
  logic [2:0]        count;

  fu_cdb_tx #(.DEPTH(DEPTH), .ROB_W(ROB_W), .PR_W(PR_W)) dut (
    .clock(clock), .reset(reset), .en(en), .fu_valid(fu_valid),
    .fu_T_idx(fu_T_idx), .fu_ROB_idx(fu_ROB_idx), .fu_dest_idx(fu_dest_idx),
    .fu_result(fu_result), .fu_stall(fu_stall), .CDB_valid(CDB_valid),
    .rollback_en(rollback_en), .ROB_rollback_idx(ROB_rollback_idx), .diff_ROB(diff_ROB),
    .done(done), .T_idx(T_idx), .ROB_idx(ROB_idx), .dest_idx(dest_idx),
    .result(result), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          live;
    int          t;
    int          rob;
    int          dest;
    logic [63:0] res;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   last_done;
  int   last_rob;
  int   seen[$];

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit sq(int x);
    int d;
    d = (x - int'(ROB_rollback_idx) + ROBN) % ROBN;
    return rollback_en && d >= 1 && d <= int'(diff_ROB);
  endfunction

  task automatic drive(bit e, bit fv, int rob, int t, int dst, logic [63:0] res,
                       bit cdb, bit rb, int rbi, int dif);
    en = e; fu_valid = fv; fu_ROB_idx = ROB_W'(rob); fu_T_idx = PR_W'(t);
    fu_dest_idx = 5'(dst); fu_result = res; CDB_valid = cdb;
    rollback_en = rb; ROB_rollback_idx = ROB_W'(rbi); diff_ROB = ROB_W'(dif);
  endtask

  // Checks outputs mid-cycle against the model, then advances the model over one edge.
  task automatic step(string tag);
    bit ed, es, pop;
    #1;
    ed = en && q.size() != 0 && q[0].live && !sq(q[0].rob);
    es = (q.size() == DEPTH) || !en;
    check_eq({tag, ".done"}, done, ed);
    check_eq({tag, ".stall"}, fu_stall, es);
    check_eq({tag, ".count"}, count, q.size());
    check_eq({tag, ".proto"}, fu_valid & fu_stall, 0);
    if (ed) begin
      check_eq({tag, ".T_idx"}, T_idx, q[0].t);
      check_eq({tag, ".ROB_idx"}, ROB_idx, q[0].rob);
      check_eq({tag, ".dest_idx"}, dest_idx, q[0].dest);
      check_eq({tag, ".result"}, result, q[0].res);
    end
    last_done = done;
    last_rob  = int'(ROB_idx);
    pop = en && q.size() != 0 && ((ed && CDB_valid) || !q[0].live);
    @(posedge clock);
    if (en) begin
      if (rollback_en) foreach (q[i]) if (sq(q[i].rob)) q[i].live = 0;
      if (pop) void'(q.pop_front());
      if (fu_valid && !es && !sq(int'(fu_ROB_idx)))
        q.push_back('{1, int'(fu_T_idx), int'(fu_ROB_idx), int'(fu_dest_idx), fu_result});
    end
    #1;
  endtask

  task automatic idle(int n, bit cdb);
    for (int k = 0; k < n; k++) begin
      drive(1, 0, 0, 0, 0, 64'h0, cdb, 0, 0, 0);
      step("idle");
    end
  endtask

  initial begin
    en = 1'b1;
    #3;
    check_eq("rst.done", done, 0);
    check_eq("rst.stall", fu_stall, 0);
    check_eq("rst.count", count, 0);
    check_eq("rst.T_idx", T_idx, 0);
    check_eq("rst.result", result, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    drive(1, 1, 3, 9, 4, 64'hDEAD, 1, 0, 0, 0);
    step("single.push");
    idle(2, 1);

    for (int k = 0; k < DEPTH; k++) begin
      drive(1, 1, 10 + k, 20 + k, k, 64'h100 + 64'(k), 0, 0, 0, 0);
      step("bp.push");
    end
    idle(1, 0);
    check_eq("bp.full_stall", last_done & fu_stall, 1);
    check_eq("bp.full_count", count, DEPTH);
    idle(6, 1);

    begin
      int robs[4] = '{30, 31, 0, 2};
      foreach (robs[k]) begin
        drive(1, 1, robs[k], k, k, 64'(robs[k]), 0, 0, 0, 0);
        step("wrap.push");
      end
    end
    drive(1, 0, 0, 0, 0, 64'h0, 0, 1, 31, 2);
    step("wrap.rb");
    seen.delete();
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 0, 0, 64'h0, 1, 0, 0, 0);
      step("wrap.out");
      if (last_done) seen.push_back(last_rob);
    end
    check_eq("wrap.n", seen.size(), 3);
    if (seen.size() == 3) begin
      check_eq("wrap.o0", seen[0], 30);
      check_eq("wrap.o1", seen[1], 31);
      check_eq("wrap.o2", seen[2], 2);
    end

    drive(1, 1, 5, 1, 1, 64'h55, 0, 0, 0, 0);
    step("head.push");
    drive(1, 0, 0, 0, 0, 64'h0, 1, 1, 4, 3);
    step("head.rb");
    check_eq("head.rb_done", last_done, 0);
    idle(2, 1);

    drive(1, 1, 7, 2, 2, 64'h77, 0, 1, 6, 4);
    step("prb.young");
    drive(1, 1, 6, 3, 3, 64'h66, 0, 1, 6, 4);
    step("prb.self");
    idle(1, 0);
    check_eq("prb.count", count, 1);
    idle(2, 1);

    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 12 + k, k, k, 64'hA0 + 64'(k), 0, 0, 0, 0);
      step("en.push");
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 64'h0, 1, 1, 11, 5);
      step("en.off");
    end
    idle(3, 1);

    for (int n = 0; n < 600; n++) begin
      bit e, fv;
      e  = ($urandom_range(0, 9) != 0);
      fv = e && (q.size() < DEPTH) && ($urandom_range(0, 2) != 0);
      drive(e, fv, int'($urandom_range(0, ROBN - 1)), int'($urandom_range(0, 63)),
            int'($urandom_range(0, 31)), {$urandom, $urandom},
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 5) == 0),
            int'($urandom_range(0, ROBN - 1)), int'($urandom_range(0, ROBN - 1)));
      step("rand");
    end

    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 20 + k, 5, 5, 64'hBEEF, 0, 0, 0, 0);
      step("ar.push");
    end
    drive(1, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0);
    reset = 1'b0;
    #2;
    check_eq("ar.done", done, 0);
    check_eq("ar.count", count, 0);
    check_eq("ar.stall", fu_stall, 0);
    check_eq("ar.ROB_idx", ROB_idx, 0);
    check_eq("ar.result", result, 0);
    q.delete();
    reset = 1'b1;
    #1;
    drive(1, 1, 9, 1, 1, 64'h9, 1, 0, 0, 0);
    step("ar.after");
    idle(2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
